data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Shares the single-port data memory between two requesters: the core load/store path, which reads and writes, and the LCD memory reader, which only reads. It replaces the static address mux that is driven by the board selector switch. Requests are granted cycle by cycle with a starvation guard. Read data is routed back to the requester that owns it, using a tag pipeline matched to the memory read latency.

Parameters:
ADDR_WIDTH, 8, data memory address width
DATA_WIDTH, 32, data word width
MEM_LATENCY, 1, cycles from address sampled to mem_q valid (1..4)
STARVE_LIMIT, 4, consecutive denied LCD request cycles before LCD is forced a grant (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
force_lcd  in  1  selector key; 1 = LCD has absolute priority (debug freeze of core memory access)
core_req  in  1  core access request, held until granted
core_we  in  1  1 = write, 0 = read; qualified by core_req
core_addr  in  ADDR_WIDTH  core address
core_wdata  in  DATA_WIDTH  core write data
core_gnt  out  1  core request accepted this cycle
core_rvalid  out  1  one-cycle pulse, core_rdata valid
core_rdata  out  DATA_WIDTH  core read data, holds last value
lcd_req  in  1  LCD read request, held until granted
lcd_addr  in  ADDR_WIDTH  LCD address
lcd_gnt  out  1  LCD request accepted this cycle
lcd_rvalid  out  1  one-cycle pulse, lcd_rdata valid
lcd_rdata  out  DATA_WIDTH  LCD read data, holds last value
mem_addr  out  ADDR_WIDTH  to data memory address
mem_data  out  DATA_WIDTH  to data memory write data
mem_wren  out  1  to data memory write enable
mem_q  in  DATA_WIDTH  from data memory output
starve_evt  out  1  one-cycle pulse when a forced LCD grant occurs (debug LED)

Behaviour:
- Reset (async, rst_n=0): FSM=ARB_CORE; starve counter=0; tag pipeline cleared; core_rdata=lcd_rdata=0; rvalids=0; starve_evt=0. Gnts and mem_wren are forced to 0 while rst_n=0. mem_addr=0 and mem_data=0.
- Grants are combinational from the requests and the registered FSM/counter. At most one grant per cycle. A requester must keep its req and inputs stable until it sees its gnt.
- Memory drive is combinational from the granted requester:
  - Core granted: mem_addr=core_addr, mem_data=core_wdata, mem_wren=core_we.
  - LCD granted: mem_addr=lcd_addr, mem_wren=0, mem_data=0.
  - No grant: mem_addr holds the last granted address (registered copy) and mem_wren=0.
- Arbitration, in priority order:
  - force_lcd=1: LCD wins any contention; the core gets grants only when lcd_req=0. The counter is held at 0.
  - Only one req: that requester is granted.
  - Both req, FSM=ARB_CORE: the core is granted. The counter increments, saturating at STARVE_LIMIT.
  - Both req, FSM=ARB_LCD: the LCD is granted. starve_evt pulses in the same cycle. FSM returns to ARB_CORE and the counter clears.
- FSM transitions:
  - ARB_CORE -> ARB_LCD when the counter reaches STARVE_LIMIT.
  - ARB_LCD -> ARB_CORE after any LCD grant.
  - In either state, lcd_req=0 clears the counter.
- Read return:
  - Each granted read (core read or LCD) pushes the tag {valid, owner} into a MEM_LATENCY-deep shift register. Writes push valid=0.
  - When the tag exits the register (the cycle mem_q is valid), mem_q is registered into the owner's rdata. The owner's rvalid pulses in the next cycle.
  - Grant-to-rvalid latency is MEM_LATENCY+1 cycles. Throughput is one access per cycle.
  - Back-to-back reads to alternating owners return in grant order, with no bubbles.
- A core write followed by a core read of the same address on the next cycle returns the new data. This relies on the memory's old-data/new-data behaviour, which is fixed as new-data.
- Reset mid-operation drops in-flight tags; no rvalid is issued for them.
- force_lcd may change on any cycle and takes effect in the same cycle.

Decomposition:
- Shared package (musa_pkg): the owner encoding (OWN_CORE=0, OWN_LCD=1) and the FSM state encoding (ARB_CORE, ARB_LCD).
- One sub-module is natural: arb_tag_pipe, a parameterized MEM_LATENCY-deep {valid, owner} shift register with async reset.

Test Plan:
1. Core write 0xDEADBEEF to address 0x10, then core read of 0x10: core_gnt is 1 for each; core_rvalid at grant+2 with core_rdata=0xDEADBEEF; lcd_rvalid stays 0.
2. LCD-only reads of addresses 0x00..0x03, with preloaded words 0x11..0x14: four consecutive lcd_gnt; lcd_rvalid pulses on four consecutive cycles with data 0x11..0x14; mem_wren stays 0.
3. Both req held continuously, STARVE_LIMIT=4: core granted for 4 cycles, then LCD granted for 1 cycle with starve_evt=1, then the pattern repeats. The ratio measured over 50 cycles is 4:1.
4. force_lcd=1 with both req held: lcd_gnt=1 every cycle, core_gnt=0. Dropping lcd_req gives core_gnt=1 in the same cycle.
5. Alternating grants core(0x20)/lcd(0x21)/core(0x22): rvalids arrive in the same order, each carrying the correct owner's data. No cross-delivery occurs.
6. Core read granted, then rst_n pulsed low in the following cycle: no rvalid ever appears, all outputs are at their reset values during reset, and the first grant after reset works normally.

Source files
------------

// File: rtl/musa_pkg.sv
// Shared encodings for the data memory arbiter: requester ownership and arbitration state.
package musa_pkg;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_LCD  = 1'b1
    } owner_e;

    typedef enum logic {
        ARB_CORE = 1'b0,
        ARB_LCD  = 1'b1
    } arb_state_e;

    // Wide enough for the largest starvation limit (15).
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/arb_tag_pipe.sv
// Shift register of {valid, owner} tags, one stage per cycle of memory read latency.
module arb_tag_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid,
    input  logic push_owner,
    output logic pop_valid,
    output logic pop_owner
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] owner_q, owner_d;

    always_comb begin
        valid_d    = valid_q;
        owner_d    = owner_q;
        valid_d[0] = push_valid;
        owner_d[0] = push_owner;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            owner_d[i] = owner_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    assign pop_valid = valid_q[DEPTH-1];
    assign pop_owner = owner_q[DEPTH-1];

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter for the single-port data memory: core load/store and LCD reader,
// with a starvation guard and tagged read-data return.
module data_mem_arbiter
    import musa_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  force_lcd,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  lcd_req,
    input  logic [ADDR_WIDTH-1:0] lcd_addr,
    output logic                  lcd_gnt,
    output logic                  lcd_rvalid,
    output logic [DATA_WIDTH-1:0] lcd_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  starve_evt
);

    localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

    arb_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  last_addr_q, last_addr_d;
    logic [DATA_WIDTH-1:0]  core_rdata_q, core_rdata_d;
    logic [DATA_WIDTH-1:0]  lcd_rdata_q, lcd_rdata_d;
    logic                   core_rvalid_q, core_rvalid_d;
    logic                   lcd_rvalid_q, lcd_rvalid_d;
    logic                   core_gnt_raw, lcd_gnt_raw, starve_raw;
    logic                   push_valid, pop_valid, pop_owner;
    owner_e                 push_owner;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        core_gnt_raw = 1'b0;
        lcd_gnt_raw  = 1'b0;
        starve_raw   = 1'b0;
        if (force_lcd) begin
            lcd_gnt_raw  = lcd_req;
            core_gnt_raw = core_req & ~lcd_req;
            cnt_d        = '0;
            if (lcd_req) state_d = ARB_CORE;
        end else if (core_req && lcd_req) begin
            if (state_q == ARB_LCD) begin
                lcd_gnt_raw = 1'b1;
                starve_raw  = 1'b1;
                state_d     = ARB_CORE;
                cnt_d       = '0;
            end else begin
                core_gnt_raw = 1'b1;
                if (cnt_q < Limit) cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == Limit) state_d = ARB_LCD;
            end
        end else if (core_req) begin
            core_gnt_raw = 1'b1;
        end else if (lcd_req) begin
            lcd_gnt_raw = 1'b1;
            state_d     = ARB_CORE;
            cnt_d       = '0;
        end
        if (!lcd_req) cnt_d = '0;
    end

    // Grants must be inactive while reset is held, independent of requests.
    assign core_gnt   = core_gnt_raw & rst_n;
    assign lcd_gnt    = lcd_gnt_raw & rst_n;
    assign starve_evt = starve_raw & rst_n;

    always_comb begin
        mem_addr = last_addr_q;
        mem_data = '0;
        mem_wren = 1'b0;
        if (core_gnt) begin
            mem_addr = core_addr;
            mem_data = core_wdata;
            mem_wren = core_we;
        end else if (lcd_gnt) begin
            mem_addr = lcd_addr;
        end
        last_addr_d = mem_addr;
    end

    assign push_valid = lcd_gnt | (core_gnt & ~core_we);
    assign push_owner = lcd_gnt ? OWN_LCD : OWN_CORE;

    arb_tag_pipe #(
        .DEPTH(MEM_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_valid(push_valid),
        .push_owner(push_owner),
        .pop_valid (pop_valid),
        .pop_owner (pop_owner)
    );

    always_comb begin
        core_rvalid_d = pop_valid & (pop_owner == OWN_CORE);
        lcd_rvalid_d  = pop_valid & (pop_owner == OWN_LCD);
        core_rdata_d  = core_rvalid_d ? mem_q : core_rdata_q;
        lcd_rdata_d   = lcd_rvalid_d ? mem_q : lcd_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_CORE;
            cnt_q         <= '0;
            last_addr_q   <= '0;
            core_rdata_q  <= '0;
            lcd_rdata_q   <= '0;
            core_rvalid_q <= 1'b0;
            lcd_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_addr_q   <= last_addr_d;
            core_rdata_q  <= core_rdata_d;
            lcd_rdata_q   <= lcd_rdata_d;
            core_rvalid_q <= core_rvalid_d;
            lcd_rvalid_q  <= lcd_rvalid_d;
        end
    end

    assign core_rdata  = core_rdata_q;
    assign lcd_rdata   = lcd_rdata_q;
    assign core_rvalid = core_rvalid_q;
    assign lcd_rvalid  = lcd_rvalid_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a one-cycle new-data synchronous memory model.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        force_lcd;
    logic        core_req, core_we;
    logic [7:0]  core_addr;
    logic [31:0] core_wdata;
    logic        core_gnt, core_rvalid;
    logic [31:0] core_rdata;
    logic        lcd_req;
    logic [7:0]  lcd_addr;
    logic        lcd_gnt, lcd_rvalid;
    logic [31:0] lcd_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic        starve_evt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (32),
        .MEM_LATENCY (1),
        .STARVE_LIMIT(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .force_lcd  (force_lcd),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .lcd_req    (lcd_req),
        .lcd_addr   (lcd_addr),
        .lcd_gnt    (lcd_gnt),
        .lcd_rvalid (lcd_rvalid),
        .lcd_rdata  (lcd_rdata),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q),
        .starve_evt (starve_evt)
    );

    // Memory model: contents reseeded while reset is low, new-data on write.
    logic [31:0] mem [256];

    function automatic logic [31:0] seed(input int a);
        case (a)
            0:       seed = 32'h11;
            1:       seed = 32'h12;
            2:       seed = 32'h13;
            3:       seed = 32'h14;
            'h20:    seed = 32'hA0A0_A0A0;
            'h21:    seed = 32'hB1B1_B1B1;
            'h22:    seed = 32'hC2C2_C2C2;
            default: seed = 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed(i);
            mem_q <= 32'h0;
        end else begin
            if (mem_wren) mem[mem_addr] <= mem_data;
            mem_q <= mem_wren ? mem_data : mem[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req = 1'b0;
        core_we  = 1'b0;
        lcd_req  = 1'b0;
    endtask

    int n_core, n_lcd, n_starve;

    initial begin
        rst_n      = 1'b0;
        force_lcd  = 1'b0;
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 8'h55;
        core_wdata = 32'h1234_5678;
        lcd_req    = 1'b1;
        lcd_addr   = 8'h66;
        #12;
        check_eq("rst_core_gnt", core_gnt, 0);
        check_eq("rst_lcd_gnt", lcd_gnt, 0);
        check_eq("rst_wren", mem_wren, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_data", mem_data, 0);
        check_eq("rst_rvalids", {core_rvalid, lcd_rvalid, starve_evt}, 0);
        check_eq("rst_rdata", core_rdata | lcd_rdata, 0);
        idle();
        tick(); tick();
        rst_n = 1'b1;

        // Test 1: write then read-back of the same address.
        tick();
        core_req = 1; core_we = 1; core_addr = 8'h10; core_wdata = 32'hDEAD_BEEF;
        #1;
        check_eq("t1_wr_gnt", core_gnt, 1);
        check_eq("t1_wr_wren", mem_wren, 1);
        check_eq("t1_wr_addr", mem_addr, 8'h10);
        check_eq("t1_wr_data", mem_data, 32'hDEAD_BEEF);
        tick();
        core_we = 0;
        #1;
        check_eq("t1_rd_gnt", core_gnt, 1);
        check_eq("t1_rd_wren", mem_wren, 0);
        tick();
        idle();
        #1;
        check_eq("t1_rv_early", core_rvalid, 0);
        check_eq("t1_hold_addr", mem_addr, 8'h10);
        tick(); #1;
        check_eq("t1_rvalid", core_rvalid, 1);
        check_eq("t1_rdata", core_rdata, 32'hDEAD_BEEF);
        check_eq("t1_lcd_rv", lcd_rvalid, 0);
        tick(); #1;
        check_eq("t1_rv_pulse", core_rvalid, 0);

        // Test 2: four back-to-back LCD reads.
        for (int i = 0; i < 4; i++) begin
            tick();
            lcd_req = 1; lcd_addr = 8'(i);
            #1;
            check_eq("t2_gnt", lcd_gnt, 1);
            check_eq("t2_wren", mem_wren, 0);
            if (i >= 2) begin
                check_eq("t2_rvalid", lcd_rvalid, 1);
                check_eq("t2_rdata", lcd_rdata, 32'h11 + 32'(i - 2));
            end else begin
                check_eq("t2_rv_early", lcd_rvalid, 0);
            end
        end
        for (int i = 2; i < 4; i++) begin
            tick();
            idle();
            #1;
            check_eq("t2_rvalid", lcd_rvalid, 1);
            check_eq("t2_rdata", lcd_rdata, 32'h11 + 32'(i));
        end
        tick(); #1;
        check_eq("t2_rv_end", lcd_rvalid, 0);

        // Test 3: continuous contention, expect core x4 then forced LCD x1.
        n_core = 0; n_lcd = 0; n_starve = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            core_req = 1; core_we = 0; core_addr = 8'h30;
            lcd_req = 1; lcd_addr = 8'h31;
            #1;
            check_eq("t3_pattern", {core_gnt, lcd_gnt, starve_evt},
                     (k % 5 == 4) ? 3'b011 : 3'b100);
            n_core   += int'(core_gnt);
            n_lcd    += int'(lcd_gnt);
            n_starve += int'(starve_evt);
        end
        check_eq("t3_core_cnt", n_core, 40);
        check_eq("t3_lcd_cnt", n_lcd, 10);
        check_eq("t3_starve_cnt", n_starve, 10);
        tick();
        idle();

        // Test 4: force_lcd overrides; core gets through once LCD drops.
        for (int k = 0; k < 6; k++) begin
            tick();
            force_lcd = 1; core_req = 1; lcd_req = 1; lcd_addr = 8'h02;
            #1;
            check_eq("t4_grants", {core_gnt, lcd_gnt, starve_evt}, 3'b010);
        end
        tick();
        lcd_req = 0;
        #1;
        check_eq("t4_core_gnt", {core_gnt, lcd_gnt}, 2'b10);
        tick();
        force_lcd = 0;
        idle();
        tick(); tick(); tick();

        // Test 5: alternating owners return in order without cross-delivery.
        tick();
        core_req = 1; core_addr = 8'h20;
        #1;
        check_eq("t5_g0", {core_gnt, lcd_gnt}, 2'b10);
        tick();
        core_req = 0; lcd_req = 1; lcd_addr = 8'h21;
        #1;
        check_eq("t5_g1", {core_gnt, lcd_gnt}, 2'b01);
        tick();
        core_req = 1; core_addr = 8'h22; lcd_req = 0;
        #1;
        check_eq("t5_g2", {core_gnt, lcd_gnt}, 2'b10);
        check_eq("t5_rv0", {core_rvalid, lcd_rvalid}, 2'b10);
        check_eq("t5_d0", core_rdata, 32'hA0A0_A0A0);
        tick();
        idle();
        #1;
        check_eq("t5_rv1", {core_rvalid, lcd_rvalid}, 2'b01);
        check_eq("t5_d1", lcd_rdata, 32'hB1B1_B1B1);
        tick(); #1;
        check_eq("t5_rv2", {core_rvalid, lcd_rvalid}, 2'b10);
        check_eq("t5_d2", core_rdata, 32'hC2C2_C2C2);
        check_eq("t5_lcd_hold", lcd_rdata, 32'hB1B1_B1B1);

        // Test 6: reset drops an in-flight read.
        tick(); tick();
        core_req = 1; core_addr = 8'h10;
        #1;
        check_eq("t6_gnt", core_gnt, 1);
        tick();
        idle();
        rst_n = 0;
        #1;
        check_eq("t6_rst_rv", {core_rvalid, lcd_rvalid}, 2'b00);
        check_eq("t6_rst_rdata", core_rdata | lcd_rdata, 0);
        check_eq("t6_rst_addr", mem_addr, 0);
        core_req = 1; core_we = 1;
        #1;
        check_eq("t6_rst_gnt", {core_gnt, lcd_gnt, mem_wren}, 3'b000);
        tick();
        idle();
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("t6_no_rv", {core_rvalid, lcd_rvalid}, 2'b00);
            tick();
        end
        core_req = 1; core_addr = 8'h21;
        #1;
        check_eq("t6_post_gnt", core_gnt, 1);
        tick();
        idle();
        tick(); #1;
        check_eq("t6_post_rv", core_rvalid, 1);
        check_eq("t6_post_data", core_rdata, 32'hB1B1_B1B1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
